// File: rtl/note_scheduler.sv
// Rhythm-game beat scheduler: shows a target LED pattern each beat and judges
// the first fresh key press inside the beat's window as a hit or a miss.
module note_scheduler #(
    parameter int unsigned TICKS_PER_BEAT = 50000000,
    parameter int unsigned WINDOW_TICKS   = 25000000,
    parameter int unsigned BEATS_PER_GAME = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [3:0] keys,
    input  logic [6:0] rnd,
    output logic       rnd_step,
    output logic [3:0] led_pattern,
    output logic [4:0] timer,
    output logic [7:0] score,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       playing,
    output logic       done
);

    localparam int unsigned GAP_TICKS = TICKS_PER_BEAT - WINDOW_TICKS - 1;
    localparam int unsigned CW        = (TICKS_PER_BEAT > 2) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [CW-1:0] WIN_LAST   = CW'(WINDOW_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
    localparam logic [4:0]    TIMER_INIT = 5'(BEATS_PER_GAME);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM_WAIT  = 3'd1,
        BEAT_LOAD = 3'd2,
        WINDOW    = 3'd3,
        GAP       = 3'd4,
        END       = 3'd5,
        END_WAIT  = 3'd6
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    prev_keys;
    logic          judged;
    logic          hit, miss;
    logic          press, win_last, gap_last;

    function automatic logic [3:0] pattern_of(input logic [6:0] r);
        logic [3:0] p;
        case (r % 7'd10)
            7'd0:    p = 4'b0001;
            7'd1:    p = 4'b0010;
            7'd2:    p = 4'b0100;
            7'd3:    p = 4'b1000;
            7'd4:    p = 4'b0011;
            7'd5:    p = 4'b0110;
            7'd6:    p = 4'b1100;
            7'd7:    p = 4'b1001;
            7'd8:    p = 4'b0101;
            default: p = 4'b1111;
        endcase
        return p;
    endfunction

    assign press    = (keys != '0) && (prev_keys == '0);
    assign win_last = (cnt == WIN_LAST);
    assign gap_last = (cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (resetn) state <= IDLE;
        else        state <= state_next;
    end

    // Strobes are Mealy on the press so a press on the last window cycle still
    // pre-empts the no-press miss; reset masks them so no judgment leaks out.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE:      if (go) state_next = ARM_WAIT;
            ARM_WAIT:  if (!go) state_next = BEAT_LOAD;
            BEAT_LOAD: state_next = WINDOW;
            WINDOW: begin
                if (!judged) begin
                    if (press) begin
                        if (keys == led_pattern) hit = 1'b1;
                        else                     miss = 1'b1;
                    end else if (win_last) begin
                        miss = 1'b1;
                    end
                end
                if (win_last) state_next = GAP;
            end
            GAP:       if (gap_last) state_next = (timer == 5'd1) ? END : BEAT_LOAD;
            END:       if (go) state_next = END_WAIT;
            END_WAIT:  if (!go) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (resetn) begin
            state_next = IDLE;
            hit        = 1'b0;
            miss       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        prev_keys <= keys;
        if (resetn) begin
            timer       <= TIMER_INIT;
            score       <= '0;
            led_pattern <= '0;
            cnt         <= '0;
            judged      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        score <= '0;
                        timer <= TIMER_INIT;
                    end
                end
                BEAT_LOAD: begin
                    led_pattern <= pattern_of(rnd);
                    cnt         <= '0;
                    judged      <= 1'b0;
                end
                WINDOW: begin
                    cnt <= win_last ? '0 : cnt + CW'(1);
                    if (hit || miss) begin
                        judged      <= 1'b1;
                        led_pattern <= '0;
                    end
                    if (hit && (score != 8'hFF)) score <= score + 8'd1;
                end
                GAP: begin
                    cnt <= gap_last ? '0 : cnt + CW'(1);
                    if (gap_last) timer <= timer - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign hit_pulse  = hit;
    assign miss_pulse = miss;
    assign rnd_step   = !resetn && (state == BEAT_LOAD);
    assign playing    = !resetn && ((state == BEAT_LOAD) || (state == WINDOW) || (state == GAP));
    assign done       = !resetn && ((state == END) || (state == END_WAIT));

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed literal scenarios plus random play, all
// checked every cycle against a beat-position model of the game.
module tb_note_scheduler;

    localparam int TPB = 8;
    localparam int WT  = 4;
    localparam int BPG = 3;

    logic       clk;
    logic       resetn;
    logic       go;
    logic [3:0] keys;
    logic [6:0] rnd;
    logic       rnd_step;
    logic [3:0] led_pattern;
    logic [4:0] timer;
    logic [7:0] score;
    logic       hit_pulse, miss_pulse, playing, done;

    int checks   = 0;
    int failures = 0;

    note_scheduler #(
        .TICKS_PER_BEAT(TPB),
        .WINDOW_TICKS  (WT),
        .BEATS_PER_GAME(BPG)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .keys       (keys),
        .rnd        (rnd),
        .rnd_step   (rnd_step),
        .led_pattern(led_pattern),
        .timer      (timer),
        .score      (score),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .playing    (playing),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: a mode plus position within the current beat (0 = load,
    // 1..WT = window, the rest gap).
    typedef enum {M_IDLE, M_ARM, M_PLAY, M_END, M_ENDW} mode_t;

    logic [3:0] pat_tab [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                 4'b0110, 4'b1100, 4'b1001, 4'b0101, 4'b1111};

    mode_t m_mode  = M_IDLE;
    int    m_pos   = 0;
    int    m_timer = BPG;
    int    m_score = 0;
    int    m_led   = 0;
    bit    m_judged = 0;
    int    m_prev  = 0;
    bit    m_valid = 0;

    always @(negedge clk) begin
        bit in_win, e_press, e_hit, e_miss, e_step, e_play, e_done;
        in_win  = (m_mode == M_PLAY) && (m_pos >= 1) && (m_pos <= WT);
        e_press = (keys != 4'd0) && (m_prev == 0);
        e_hit   = !resetn && in_win && !m_judged && e_press && (int'(keys) == m_led);
        e_miss  = !resetn && in_win && !m_judged &&
                  (e_press ? (int'(keys) != m_led) : (m_pos == WT));
        e_step  = !resetn && (m_mode == M_PLAY) && (m_pos == 0);
        e_play  = !resetn && (m_mode == M_PLAY);
        e_done  = !resetn && ((m_mode == M_END) || (m_mode == M_ENDW));
        if (m_valid) begin
            chk("m_timer", int'(timer), m_timer);
            chk("m_score", int'(score), m_score);
            chk("m_led", int'(led_pattern), m_led);
            chk("m_hit", int'(hit_pulse), int'(e_hit));
            chk("m_miss", int'(miss_pulse), int'(e_miss));
            chk("m_step", int'(rnd_step), int'(e_step));
            chk("m_playing", int'(playing), int'(e_play));
            chk("m_done", int'(done), int'(e_done));
        end
        m_prev = int'(keys);
        if (resetn) begin
            m_mode = M_IDLE; m_pos = 0; m_timer = BPG; m_score = 0;
            m_led = 0; m_judged = 0; m_valid = 1;
        end else begin
            case (m_mode)
                M_IDLE: if (go) begin m_mode = M_ARM; m_score = 0; m_timer = BPG; end
                M_ARM:  if (!go) begin m_mode = M_PLAY; m_pos = 0; end
                M_PLAY: begin
                    if (m_pos == 0) begin
                        m_led = int'(pat_tab[int'(rnd) % 10]);
                        m_judged = 0;
                    end
                    if (e_hit || e_miss) begin m_judged = 1; m_led = 0; end
                    if (e_hit && m_score < 255) m_score++;
                    if (m_pos == TPB - 1) begin
                        m_timer--;
                        m_pos = 0;
                        if (m_timer == 0) m_mode = M_END;
                    end else begin
                        m_pos++;
                    end
                end
                M_END:  if (go) m_mode = M_ENDW;
                M_ENDW: if (!go) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic cyc(input logic g, input logic [3:0] k, input logic [6:0] r, input logic rs);
        @(posedge clk);
        #1;
        go = g; keys = k; rnd = r; resetn = rs;
    endtask

    task automatic cycn(input int n, input logic [6:0] r);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, r, 1'b0);
    endtask

    initial begin
        logic [3:0] k;
        resetn = 1'b1; go = 1'b0; keys = 4'd0; rnd = 7'd0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        #1;
        chk("rst_timer", int'(timer), 3);
        chk("rst_score", int'(score), 0);
        chk("rst_led", int'(led_pattern), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_done", int'(done), 0);

        // start with rnd=23 -> pattern 1000
        cyc(1, 0, 23, 0);
        cyc(1, 0, 23, 0);
        cyc(0, 0, 23, 0);
        cyc(0, 0, 23, 0);
        #1;
        chk("start_step", int'(rnd_step), 1);
        chk("start_playing", int'(playing), 1);
        chk("start_timer", int'(timer), 3);
        cyc(0, 0, 23, 0);
        #1;
        chk("w1_led", int'(led_pattern), 8);
        chk("w1_step", int'(rnd_step), 0);
        cyc(0, 4'b1000, 23, 0);
        #1;
        chk("hit_pulse", int'(hit_pulse), 1);
        chk("hit_nomiss", int'(miss_pulse), 0);
        cyc(0, 0, 23, 0);
        #1;
        chk("hit_score", int'(score), 1);
        chk("hit_ledclr", int'(led_pattern), 0);
        cyc(0, 4'b0100, 23, 0);
        #1;
        chk("late_nohit", int'(hit_pulse), 0);
        chk("late_nomiss", int'(miss_pulse), 0);
        cycn(3, 23);

        // beat 2: wrong key
        cyc(0, 0, 23, 0);
        #1;
        chk("b2_timer", int'(timer), 2);
        chk("b2_step", int'(rnd_step), 1);
        cyc(0, 4'b0001, 23, 0);
        #1;
        chk("wrong_miss", int'(miss_pulse), 1);
        chk("wrong_nohit", int'(hit_pulse), 0);
        cyc(0, 0, 23, 0);
        #1;
        chk("wrong_score", int'(score), 1);
        cycn(5, 23);

        // beat 3: no press -> miss on the 4th window cycle
        cycn(4, 23);
        cyc(0, 0, 23, 0);
        #1;
        chk("nopress_miss", int'(miss_pulse), 1);
        cycn(3, 23);
        cyc(0, 0, 23, 0);
        #1;
        chk("end_timer", int'(timer), 0);
        chk("end_done", int'(done), 1);
        chk("end_playing", int'(playing), 0);
        cyc(1, 0, 23, 0);
        cyc(0, 0, 23, 0);
        cyc(0, 0, 23, 0);
        #1;
        chk("idle_done", int'(done), 0);
        chk("idle_score", int'(score), 1);

        // held 1111 across load with rnd%10 == 9
        cyc(1, 4'hF, 9, 0);
        cyc(0, 4'hF, 9, 0);
        #1;
        chk("restart_score", int'(score), 0);
        chk("restart_timer", int'(timer), 3);
        cyc(0, 4'hF, 9, 0);
        cyc(0, 4'hF, 9, 0);
        #1;
        chk("held_nohit", int'(hit_pulse), 0);
        chk("held_nomiss", int'(miss_pulse), 0);
        chk("held_led", int'(led_pattern), 15);
        cyc(0, 0, 9, 0);
        cyc(0, 4'hF, 9, 0);
        #1;
        chk("repress_hit", int'(hit_pulse), 1);
        cyc(0, 0, 9, 0);
        #1;
        chk("repress_score", int'(score), 1);
        chk("repress_nomiss", int'(miss_pulse), 0);
        cycn(3, 9);

        // reset in the window with a matching press on the same edge
        cyc(0, 0, 9, 0);
        cyc(0, 4'hF, 9, 1);
        #1;
        chk("rstwin_nohit", int'(hit_pulse), 0);
        chk("rstwin_nomiss", int'(miss_pulse), 0);
        cyc(0, 0, 9, 0);
        #1;
        chk("rstwin_score", int'(score), 0);
        chk("rstwin_timer", int'(timer), 3);
        chk("rstwin_playing", int'(playing), 0);

        k = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      k = 4'd0;
            else if (sel == 1) k = pat_tab[$urandom_range(0, 9)];
            else if (sel == 2) k = 4'($urandom);
            cyc($urandom_range(0, 4) == 0, k, 7'($urandom), $urandom_range(0, 499) == 0);
        end
        cyc(0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
